// File: rtl/config_loader_pkg.sv
// Shared configuration constants and loader state type for the config loader
// and the logic column it feeds.
package config_loader_pkg;

  localparam int TILE_CONFIG_WIDTH = 644;
  localparam int TILES_PER_COLUMN  = 8;
  localparam int CONFIG_WIDTH      = TILE_CONFIG_WIDTH * TILES_PER_COLUMN;
  localparam int WORD_WIDTH        = 32;
  localparam int NUM_WORDS         = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int COUNT_WIDTH       = $clog2(NUM_WORDS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_e;

endpackage

// File: rtl/config_loader_if.sv
// Word-stream handshake between the external configuration port and the loader.
interface config_loader_if #(
  parameter int WORD_WIDTH = config_loader_pkg::WORD_WIDTH
);

  logic [WORD_WIDTH-1:0] cfg_data_in;
  logic                  cfg_valid;
  logic                  cfg_ready;

  modport master (
    output cfg_data_in,
    output cfg_valid,
    input  cfg_ready
  );

  modport slave (
    input  cfg_data_in,
    input  cfg_valid,
    output cfg_ready
  );

endinterface

// File: rtl/config_shift_register.sv
// Word-wide shift register holding the assembled configuration vector; new
// words enter at the LSB end so the first word of a frame ends in the MSBs.
module config_shift_register #(
  parameter int CONFIG_WIDTH = config_loader_pkg::CONFIG_WIDTH,
  parameter int WORD_WIDTH   = config_loader_pkg::WORD_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    shift_en,
  input  logic [WORD_WIDTH-1:0]   word_in,
  output logic [CONFIG_WIDTH-1:0] data_out
);

  // Clear wins over shift so a restart never keeps a word from the old frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out <= {CONFIG_WIDTH{1'b0}};
    end else if (clear) begin
      data_out <= {CONFIG_WIDTH{1'b0}};
    end else if (shift_en) begin
      data_out <= {data_out[CONFIG_WIDTH-WORD_WIDTH-1:0], word_in};
    end else begin
      data_out <= data_out;
    end
  end

endmodule

// File: rtl/config_loader.sv
// Loads the fabric bitstream word by word into config_out and holds the fabric
// in reset until a full frame has been accepted.
module config_loader #(
  parameter int CONFIG_WIDTH = config_loader_pkg::CONFIG_WIDTH,
  parameter int WORD_WIDTH   = config_loader_pkg::WORD_WIDTH
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   start,
  config_loader_if.slave                         cfg,
  output logic [CONFIG_WIDTH-1:0]                config_out,
  output logic                                   config_done,
  output logic                                   fabric_reset,
  output logic [config_loader_pkg::COUNT_WIDTH-1:0] word_count
);

  import config_loader_pkg::*;

  localparam int LOAD_WORDS = CONFIG_WIDTH / WORD_WIDTH;
  localparam logic [COUNT_WIDTH-1:0] LAST_WORD = COUNT_WIDTH'(LOAD_WORDS - 1);
  localparam logic [COUNT_WIDTH-1:0] ONE_WORD  = COUNT_WIDTH'(1);

  if ((CONFIG_WIDTH % WORD_WIDTH) != 0) begin : g_width_check
    $error("config_loader: CONFIG_WIDTH must be a multiple of WORD_WIDTH");
  end
  if (LOAD_WORDS >= (1 << COUNT_WIDTH)) begin : g_count_check
    $error("config_loader: word_count too narrow for LOAD_WORDS");
  end

  loader_state_e state_r;
  logic          ready_r;
  logic          shift_s;

  assign cfg.cfg_ready = ready_r;

  // A word is taken only in LOAD and only when no restart coincides with it.
  always_comb begin
    shift_s = 1'b0;
    if ((state_r == LOAD) && ready_r && cfg.cfg_valid && !start) begin
      shift_s = 1'b1;
    end else begin
      shift_s = 1'b0;
    end
  end

  config_shift_register #(
    .CONFIG_WIDTH (CONFIG_WIDTH),
    .WORD_WIDTH   (WORD_WIDTH)
  ) u_shift (
    .clock    (clock),
    .reset    (reset),
    .clear    (start),
    .shift_en (shift_s),
    .word_in  (cfg.cfg_data_in),
    .data_out (config_out)
  );

  // Loader FSM with registered handshake, count and status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      word_count   <= {COUNT_WIDTH{1'b0}};
      ready_r      <= 1'b0;
      config_done  <= 1'b0;
      fabric_reset <= 1'b1;
    end else if (start) begin
      state_r      <= LOAD;
      word_count   <= {COUNT_WIDTH{1'b0}};
      ready_r      <= 1'b1;
      config_done  <= 1'b0;
      fabric_reset <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= IDLE;
          ready_r <= 1'b0;
        end
        LOAD: begin
          if (shift_s) begin
            word_count <= word_count + ONE_WORD;
            if (word_count == LAST_WORD) begin
              state_r      <= DONE;
              ready_r      <= 1'b0;
              config_done  <= 1'b1;
              fabric_reset <= 1'b0;
            end else begin
              state_r <= LOAD;
            end
          end else begin
            state_r <= LOAD;
          end
        end
        DONE: begin
          state_r <= DONE;
          ready_r <= 1'b0;
        end
        default: begin
          state_r      <= IDLE;
          word_count   <= {COUNT_WIDTH{1'b0}};
          ready_r      <= 1'b0;
          config_done  <= 1'b0;
          fabric_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Directed self-checking bench for config_loader: nominal load, gaps, restart,
// asynchronous reset, reload and ignored traffic outside LOAD.
module tb_config_loader;

  localparam int CW = 5152;
  localparam int WW = 32;
  localparam int NW = 161;

  logic          clock;
  logic          reset;
  logic          start;
  logic [CW-1:0] config_out;
  logic          config_done;
  logic          fabric_reset;
  logic [7:0]    word_count;

  logic [CW-1:0] exp_seq;
  logic [CW-1:0] exp_ones;
  logic [CW-1:0] snap;
  int            n_assert;
  int            n_fail;
  int            ready_drops;

  config_loader_if #(.WORD_WIDTH(WW)) cfg_if ();

  config_loader dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .cfg          (cfg_if),
    .config_out   (config_out),
    .config_done  (config_done),
    .fabric_reset (fabric_reset),
    .word_count   (word_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed(low128)=%0h expected(low128)=%0h", tag, obs[127:0], exp[127:0]);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Sends one full frame; mode 0 sends word k = k, mode 1 sends all ones.
  task automatic load_frame(input bit mode, input bit gaps);
    ready_drops = 0;
    for (int k = 0; k < NW; k++) begin
      if (gaps) begin
        cfg_if.cfg_valid = 1'b0;
        tick();
        if (cfg_if.cfg_ready !== 1'b1) ready_drops++;
      end
      if (cfg_if.cfg_ready !== 1'b1) ready_drops++;
      cfg_if.cfg_valid   = 1'b1;
      cfg_if.cfg_data_in = mode ? 32'hFFFF_FFFF : 32'(k);
      tick();
      if (k == NW - 2) begin
        chk("done_low_before_last", {{(CW-1){1'b0}}, config_done}, {CW{1'b0}});
        chk("freset_high_before_last", {{(CW-1){1'b0}}, fabric_reset}, {{(CW-1){1'b0}}, 1'b1});
      end
    end
    cfg_if.cfg_valid = 1'b0;
    chk("ready_never_dropped", CW'(ready_drops), {CW{1'b0}});
    chk("done_after_last", {{(CW-1){1'b0}}, config_done}, {{(CW-1){1'b0}}, 1'b1});
    chk("freset_released", {{(CW-1){1'b0}}, fabric_reset}, {CW{1'b0}});
    chk("count_full", CW'(word_count), CW'(NW));
    chk("ready_low_in_done", {{(CW-1){1'b0}}, cfg_if.cfg_ready}, {CW{1'b0}});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic idle_traffic(input string tag, input logic [CW-1:0] exp_cfg, input logic [7:0] exp_cnt);
    int ready_seen;
    ready_seen = 0;
    cfg_if.cfg_valid   = 1'b1;
    cfg_if.cfg_data_in = 32'h1234_5678;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cfg_if.cfg_ready !== 1'b0) ready_seen++;
    end
    cfg_if.cfg_valid = 1'b0;
    chk({tag, "_cfg"}, config_out, exp_cfg);
    chk({tag, "_count"}, CW'(word_count), CW'(exp_cnt));
    chk({tag, "_ready"}, CW'(ready_seen), {CW{1'b0}});
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    exp_seq  = {CW{1'b0}};
    for (int k = 0; k < NW; k++) exp_seq = {exp_seq[CW-WW-1:0], 32'(k)};
    exp_ones = {CW{1'b1}};

    reset = 1'b1;
    start = 1'b0;
    cfg_if.cfg_valid   = 1'b0;
    cfg_if.cfg_data_in = 32'h0000_0000;
    tick();
    tick();
    chk("rst_cfg", config_out, {CW{1'b0}});
    chk("rst_count", CW'(word_count), {CW{1'b0}});
    chk("rst_ready", {{(CW-1){1'b0}}, cfg_if.cfg_ready}, {CW{1'b0}});
    chk("rst_done", {{(CW-1){1'b0}}, config_done}, {CW{1'b0}});
    chk("rst_freset", {{(CW-1){1'b0}}, fabric_reset}, {{(CW-1){1'b0}}, 1'b1});
    reset = 1'b0;
    tick();

    idle_traffic("idle_ignore", {CW{1'b0}}, 8'd0);

    // Nominal load
    pulse_start();
    chk("start_ready", {{(CW-1){1'b0}}, cfg_if.cfg_ready}, {{(CW-1){1'b0}}, 1'b1});
    chk("start_count", CW'(word_count), {CW{1'b0}});
    load_frame(1'b0, 1'b0);
    chk("nominal_cfg", config_out, exp_seq);
    chk("nominal_top_word", CW'(config_out[CW-1:CW-WW]), {CW{1'b0}});
    chk("nominal_low_word", CW'(config_out[WW-1:0]), CW'(160));

    idle_traffic("done_ignore", exp_seq, 8'(NW));

    // Reload from DONE
    pulse_start();
    chk("reload_done", {{(CW-1){1'b0}}, config_done}, {CW{1'b0}});
    chk("reload_freset", {{(CW-1){1'b0}}, fabric_reset}, {{(CW-1){1'b0}}, 1'b1});
    chk("reload_cfg", config_out, {CW{1'b0}});
    chk("reload_ready", {{(CW-1){1'b0}}, cfg_if.cfg_ready}, {{(CW-1){1'b0}}, 1'b1});

    // Backpressure gaps on the same frame
    load_frame(1'b0, 1'b1);
    chk("gaps_cfg", config_out, exp_seq);

    // Restart mid-load
    pulse_start();
    for (int k = 0; k < 50; k++) begin
      cfg_if.cfg_valid   = 1'b1;
      cfg_if.cfg_data_in = 32'(k);
      tick();
    end
    chk("partial_count", CW'(word_count), CW'(50));
    cfg_if.cfg_data_in = 32'hDEAD_BEEF;
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    chk("restart_count", CW'(word_count), {CW{1'b0}});
    chk("restart_cfg_dropped", config_out, {CW{1'b0}});
    load_frame(1'b1, 1'b0);
    chk("restart_ones_cfg", config_out, exp_ones);

    // Asynchronous reset mid-load
    pulse_start();
    for (int k = 0; k < 100; k++) begin
      cfg_if.cfg_valid   = 1'b1;
      cfg_if.cfg_data_in = 32'(k);
      tick();
    end
    cfg_if.cfg_valid = 1'b0;
    chk("pre_reset_count", CW'(word_count), CW'(100));
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_cfg", config_out, {CW{1'b0}});
    chk("async_rst_freset", {{(CW-1){1'b0}}, fabric_reset}, {{(CW-1){1'b0}}, 1'b1});
    chk("async_rst_ready", {{(CW-1){1'b0}}, cfg_if.cfg_ready}, {CW{1'b0}});
    chk("async_rst_count", CW'(word_count), {CW{1'b0}});
    #2;
    reset = 1'b0;
    tick();
    idle_traffic("post_reset_idle", {CW{1'b0}}, 8'd0);
    pulse_start();
    load_frame(1'b0, 1'b0);
    chk("post_reset_cfg", config_out, exp_seq);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
